// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-path types: the {pc, instr} entry reused by the ID stage.
// The guarded fallbacks keep the package self-contained whatever the file order.
`ifndef RESET_PC
`define RESET_PC 32'h0000_1000
`endif

`ifndef NOP_INSTR
`define NOP_INSTR 32'h0000_0013
`endif

package fetch_buffer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_VAL  = `RESET_PC;
  localparam logic [XLEN-1:0] NOP_INSTR_VAL = `NOP_INSTR;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // What ID sees whenever no real instruction is presented.
  localparam fetch_entry_t NOP_ENTRY = '{pc: RESET_PC_VAL, instr: NOP_INSTR_VAL};

endpackage

// File: rtl/definitions.sv
// Global fetch-path constants: reset PC and the canonical NOP (addi x0,x0,0).
`ifndef FETCH_BUF_DEFINITIONS_SV
`define FETCH_BUF_DEFINITIONS_SV

`ifndef RESET_PC
`define RESET_PC 32'h0000_1000
`endif

`ifndef NOP_INSTR
`define NOP_INSTR 32'h0000_0013
`endif

`endif

// File: rtl/fetch_buffer.sv
// IF->ID instruction fetch buffer: small FIFO of {pc, instr} with valid/ready
// towards ID, full status towards IF, and a flush that drops everything.
// Optional feature: FETCH_BUF_BYPASS_EN lets an incoming word reach ID in the
// same cycle when the buffer is empty.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  logic [31:0]              fetch_pc_i,
  input  logic [31:0]              fetch_instr_i,
  output logic                     fetch_ready_o,
  output logic                     id_valid_o,
  output logic [31:0]              id_pc_o,
  output logic [31:0]              id_instr_o,
  input  logic                     id_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  fetch_entry_t in_c;
  fetch_entry_t head_c;
  fetch_entry_t out_c;
  logic         empty_c;
  logic         byp_c;
  logic         byp_take_c;
  logic         push_c;
  logic         pop_c;
  logic         wr_en_c;
  logic         rd_en_c;

  // Incoming word and current head entry.
  always_comb begin
    in_c    = '{pc: fetch_pc_i, instr: fetch_instr_i};
    head_c  = mem_q[rd_ptr_q];
    empty_c = (count_q == '0);
  end

  // Same-cycle bypass qualifier; a flush always kills it.
  always_comb begin
    byp_c = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
    byp_c = empty_c && fetch_valid_i && !flush_i;
`endif
  end

  // ID/IF facing outputs; ready depends only on occupancy, never on id_ready_i.
  always_comb begin
    fetch_ready_o = (count_q < CNT_W'(DEPTH));
    id_valid_o    = !empty_c || byp_c;
    out_c         = NOP_ENTRY;
    if (byp_c) begin
      out_c = in_c;
    end else if (!empty_c) begin
      out_c = head_c;
    end
    id_pc_o    = out_c.pc;
    id_instr_o = out_c.instr;
    count_o    = count_q;
  end

  // Handshakes; a bypassed word consumed by ID never touches storage.
  always_comb begin
    push_c     = fetch_valid_i && fetch_ready_o && !flush_i;
    pop_c      = id_valid_o && id_ready_i && !flush_i;
    byp_take_c = byp_c && id_ready_i;
    wr_en_c    = push_c && !byp_take_c;
    rd_en_c    = pop_c && !byp_take_c;
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_c) begin
        mem_d[wr_ptr_q] = in_c;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: NOP_ENTRY};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=2); covers both bypass builds.
module tb_fetch_buffer;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_pc_i;
  logic [31:0] fetch_instr_i;
  logic        fetch_ready_o;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_ready_i;
  logic [1:0]  count_o;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_buffer #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_instr_i (fetch_instr_i),
    .fetch_ready_o (fetch_ready_o),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
    .id_ready_i    (id_ready_i),
    .count_o       (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Head presented to ID: a real entry, or the NOP pair when invalid.
  task automatic exp_id(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(id_valid_o), 32'(v));
    if (v) begin
      chk({tag, "_pc"}, id_pc_o, pc);
      chk({tag, "_instr"}, id_instr_o, ins(pc));
    end else begin
      chk({tag, "_pc"}, id_pc_o, RST_PC);
      chk({tag, "_instr"}, id_instr_o, NOP);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk({tag, "_count"}, 32'(count_o), 32'(exp));
  endtask

  // Drive inputs just after a falling edge and let combinational outputs settle.
  task automatic drive(input logic fv, input logic [31:0] pc, input logic rdy, input logic fl);
    fetch_valid_i = fv;
    fetch_pc_i    = pc;
    fetch_instr_i = ins(pc);
    id_ready_i    = rdy;
    flush_i       = fl;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    exp_id("rst", 1'b0, 32'h0);
    chk("rst_ready", 32'(fetch_ready_o), 32'd1);
    chk_cnt("rst", 0);
    rst_n = 1'b1;
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_id("idle", 1'b0, 32'h0);

    // Stream 0x0, 0x4, 0x8 with ID always ready.
    drive(1'b1, 32'h0, 1'b1, 1'b0);
`ifdef FETCH_BUF_BYPASS_EN
    exp_id("s0", 1'b1, 32'h0);
`else
    exp_id("s0", 1'b0, 32'h0);
`endif
    chk_cnt("s0", 0);
    step();
    drive(1'b1, 32'h4, 1'b1, 1'b0);
`ifdef FETCH_BUF_BYPASS_EN
    exp_id("s1", 1'b1, 32'h4); chk_cnt("s1", 0);
`else
    exp_id("s1", 1'b1, 32'h0); chk_cnt("s1", 1);
`endif
    step();
    drive(1'b1, 32'h8, 1'b1, 1'b0);
`ifdef FETCH_BUF_BYPASS_EN
    exp_id("s2", 1'b1, 32'h8); chk_cnt("s2", 0);
`else
    exp_id("s2", 1'b1, 32'h4); chk_cnt("s2", 1);
`endif
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef FETCH_BUF_BYPASS_EN
    exp_id("s3", 1'b0, 32'h0); chk_cnt("s3", 0);
`else
    exp_id("s3", 1'b1, 32'h8); chk_cnt("s3", 1);
`endif
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp_id("s4", 1'b0, 32'h0);
    chk_cnt("s4", 0);

    // Fill and stall: third push refused while full.
    drive(1'b1, 32'h10, 1'b0, 1'b0);
`ifdef FETCH_BUF_BYPASS_EN
    exp_id("f0", 1'b1, 32'h10);
`else
    exp_id("f0", 1'b0, 32'h0);
`endif
    chk("f0_ready", 32'(fetch_ready_o), 32'd1);
    step();
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    exp_id("f1", 1'b1, 32'h10);
    chk_cnt("f1", 1);
    chk("f1_ready", 32'(fetch_ready_o), 32'd1);
    step();
    drive(1'b1, 32'h18, 1'b0, 1'b0);
    chk_cnt("f2", 2);
    chk("f2_ready", 32'(fetch_ready_o), 32'd0);
    exp_id("f2", 1'b1, 32'h10);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp_id("f3", 1'b1, 32'h10);
    chk_cnt("f3", 2);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp_id("f4", 1'b1, 32'h14);
    chk_cnt("f4", 1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_id("f5", 1'b0, 32'h0);
    chk_cnt("f5", 0);

    // Flush while full with a same-cycle push attempt.
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h24, 1'b0, 1'b0);
    exp_id("p0", 1'b1, 32'h20);
    step();
    drive(1'b1, 32'h28, 1'b0, 1'b1);
    chk_cnt("p1", 2);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    exp_id("p2", 1'b0, 32'h0);
    chk_cnt("p2", 0);
    chk("p2_ready", 32'(fetch_ready_o), 32'd1);

    // Flush while not full: the accepted-looking push must be dropped.
    drive(1'b1, 32'h30, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h34, 1'b1, 1'b1);
    chk_cnt("q0", 1);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp_id("q1", 1'b0, 32'h0);
    chk_cnt("q1", 0);
    step();

    // Wrap-around: prefill one entry, then ten push/pop pairs.
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      exp_id($sformatf("w%0d", i), 1'b1, 32'h100 + 32'(4 * (i - 1)));
      chk_cnt($sformatf("w%0d", i), 1);
      step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp_id("w_tail", 1'b1, 32'h128);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp_id("w_end", 1'b0, 32'h0);
    chk_cnt("w_end", 0);

    // Asynchronous reset mid-operation clears the buffer immediately.
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk_cnt("ar0", 1);
    rst_n = 1'b0;
    #1;
    chk_cnt("ar1", 0);
    exp_id("ar1", 1'b0, 32'h0);
    chk("ar1_ready", 32'(fetch_ready_o), 32'd1);
    step();
    rst_n = 1'b1;
    step();

`ifdef FETCH_BUF_BYPASS_EN
    // Zero-latency bypass into an empty buffer.
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    exp_id("b0", 1'b1, 32'h40);
    chk_cnt("b0", 0);
    step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    exp_id("b1", 1'b0, 32'h0);
    chk_cnt("b1", 0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
